// File: rtl/button_debouncer.sv
// Mechanical button conditioner: 2-flop synchronizer, debounce FSM, and
// registered press/release/long-press pulses plus a wrapping press counter.
module button_debouncer #(
  parameter int ACTIVE_LOW        = 1,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 200000000,
  parameter int COUNT_WIDTH       = 8
) (
  input  logic                   sysclk2,
  input  logic                   rst_n,
  input  logic                   btn_in,
  output logic                   btn_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_press_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LPW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic             INACT   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0]   DB_ONE  = DBW'(1);
  localparam logic [LPW-1:0]   LP_MAX  = LPW'(LONG_PRESS_CYCLES);
  localparam logic [LPW-1:0]   LP_PRE  = LPW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [DBW-1:0]         db_cnt_q, db_cnt_d;
  logic [LPW-1:0]         lp_cnt_q, lp_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   long_q, long_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   act;
  logic                   lp_run;

  // Synchronizer resets to the inactive pin level so reset never looks like a press.
  always_ff @(posedge sysclk2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INACT;
      sync2_q <= INACT;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign act = sync2_q ^ INACT;

  always_ff @(posedge sysclk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      lp_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      lp_cnt_q <= lp_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    lp_cnt_d = lp_cnt_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    lp_run   = 1'b0;
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d  = DB_PRESS;
          db_cnt_d = DB_ONE;
        end
      end
      DB_PRESS: begin
        if (!act) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
          lp_cnt_d = '0;
          press_d  = 1'b1;
          level_d  = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        lp_run = 1'b1;
        if (!act) begin
          state_d  = DB_RELEASE;
          db_cnt_d = DB_ONE;
        end
      end
      DB_RELEASE: begin
        // Hold time keeps accruing through a release bounce; it stops only on an accepted release.
        if (act) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
          lp_run   = 1'b1;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
          rel_d    = 1'b1;
          level_d  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
          lp_run   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturation means the long-press pulse can fire only once per press.
    if (lp_run && (lp_cnt_q != LP_MAX)) begin
      lp_cnt_d = lp_cnt_q + 1'b1;
      long_d   = (lp_cnt_q == LP_PRE);
    end
  end

  assign btn_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = rel_q;
  assign long_press_pulse = long_q;
  assign press_count      = cnt_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=40.
module tb_button_debouncer;

  logic       sysclk2 = 1'b0;
  logic       rst_n   = 1'b0;
  logic       btn_in  = 1'b1;
  logic       btn_level, press_pulse, release_pulse, long_press_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press = -1, last_rel = -1, last_long = -1;
  int n_overlap = 0, n_wide = 0;
  logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0;

  button_debouncer #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8), .LONG_PRESS_CYCLES(40), .COUNT_WIDTH(8)
  ) dut (
    .sysclk2(sysclk2), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse), .press_count(press_count)
  );

  always #5 sysclk2 = ~sysclk2;

  always @(posedge sysclk2) cyc <= cyc + 1;

  // Pulse recorder: cycle stamp is the index of the edge that made the pulse visible.
  always @(negedge sysclk2) begin
    if (press_pulse)      begin n_press = n_press + 1; last_press = cyc; end
    if (release_pulse)    begin n_rel   = n_rel + 1;   last_rel   = cyc; end
    if (long_press_pulse) begin n_long  = n_long + 1;  last_long  = cyc; end
    if ((int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse)) > 1)
      n_overlap = n_overlap + 1;
    if ((press_pulse && prev_p) || (release_pulse && prev_r) || (long_press_pulse && prev_l))
      n_wide = n_wide + 1;
    prev_p = press_pulse;
    prev_r = release_pulse;
    prev_l = long_press_pulse;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk2);
      #1;
    end
  endtask

  task automatic apply_reset;
    btn_in = 1'b1;
    rst_n  = 1'b0;
    tick(2);
    rst_n  = 1'b1;
    tick(2);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    btn_in = 1'b1;
    tick(3);
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {btn_level, press_pulse, release_pulse, long_press_pulse});
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", press_count);
    end
    rst_n = 1'b1;
    tick(12);
    checks++;
    if (btn_level !== 1'b0 || n_press != 0) begin
      errors++; $display("FAIL reset_idle: level %b presses %0d expected 0 0", btn_level, n_press);
    end
  endtask

  task automatic test_clean_press;
    int t0, t1, p0, r0, l0;
    apply_reset();
    p0 = n_press; r0 = n_rel; l0 = n_long;
    t0 = cyc;
    btn_in = 1'b0;
    tick(100);
    checks++;
    if (n_press - p0 != 1 || last_press != t0 + 10) begin
      errors++;
      $display("FAIL clean_press: got %0d pulses at %0d expected 1 at %0d", n_press - p0, last_press, t0 + 10);
    end
    checks++;
    if (n_long - l0 != 1 || last_long != t0 + 50) begin
      errors++;
      $display("FAIL clean_long: got %0d pulses at %0d expected 1 at %0d", n_long - l0, last_long, t0 + 50);
    end
    checks++;
    if (btn_level !== 1'b1) begin
      errors++; $display("FAIL clean_level_held: got %b expected 1", btn_level);
    end
    t1 = cyc;
    btn_in = 1'b1;
    tick(15);
    checks++;
    if (n_rel - r0 != 1 || last_rel != t1 + 10) begin
      errors++;
      $display("FAIL clean_release: got %0d pulses at %0d expected 1 at %0d", n_rel - r0, last_rel, t1 + 10);
    end
    checks++;
    if (btn_level !== 1'b0 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL clean_final: level %b count %0d expected 0 1", btn_level, press_count);
    end
  endtask

  task automatic test_bounce_reject;
    int p0, r0, l0;
    apply_reset();
    p0 = n_press; r0 = n_rel; l0 = n_long;
    repeat (5) begin
      btn_in = 1'b0; tick(7);
      btn_in = 1'b1; tick(3);
    end
    tick(20);
    checks++;
    if ((n_press - p0) + (n_rel - r0) + (n_long - l0) != 0) begin
      errors++;
      $display("FAIL bounce_events: got %0d pulses expected 0", (n_press - p0) + (n_rel - r0) + (n_long - l0));
    end
    checks++;
    if (btn_level !== 1'b0 || press_count !== 8'd0) begin
      errors++;
      $display("FAIL bounce_state: level %b count %0d expected 0 0", btn_level, press_count);
    end
  endtask

  task automatic test_bouncy_press;
    int t, p0;
    apply_reset();
    p0 = n_press;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      btn_in = (i % 2 == 1) ? 1'b0 : 1'b1;
      t = cyc;
      tick(1);
    end
    tick(19);
    checks++;
    if (n_press - p0 != 1 || last_press != t + 10) begin
      errors++;
      $display("FAIL bouncy_press: got %0d pulses at %0d expected 1 at %0d", n_press - p0, last_press, t + 10);
    end
    btn_in = 1'b1;
    tick(15);
  endtask

  task automatic test_release_bounce;
    int t0, r0, l0;
    apply_reset();
    r0 = n_rel; l0 = n_long;
    t0 = cyc;
    btn_in = 1'b0; tick(30);
    btn_in = 1'b1; tick(5);
    btn_in = 1'b0; tick(40);
    checks++;
    if (n_rel - r0 != 0 || btn_level !== 1'b1) begin
      errors++;
      $display("FAIL relbounce_level: releases %0d level %b expected 0 1", n_rel - r0, btn_level);
    end
    checks++;
    if (n_long - l0 != 1 || last_long != t0 + 50) begin
      errors++;
      $display("FAIL relbounce_long: got %0d pulses at %0d expected 1 at %0d", n_long - l0, last_long, t0 + 50);
    end
    btn_in = 1'b1; tick(15);
    checks++;
    if (n_rel - r0 != 1 || btn_level !== 1'b0) begin
      errors++;
      $display("FAIL relbounce_release: releases %0d level %b expected 1 0", n_rel - r0, btn_level);
    end
  endtask

  task automatic test_short_press;
    int p0, r0, l0;
    apply_reset();
    p0 = n_press; r0 = n_rel; l0 = n_long;
    btn_in = 1'b0; tick(20);
    btn_in = 1'b1; tick(60);
    checks++;
    if (n_press - p0 != 1 || n_rel - r0 != 1 || n_long - l0 != 0) begin
      errors++;
      $display("FAIL short_press: press %0d release %0d long %0d expected 1 1 0",
               n_press - p0, n_rel - r0, n_long - l0);
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      btn_in = 1'b0; tick(12);
      btn_in = 1'b1; tick(12);
      if (i == 254) begin
        checks++;
        if (press_count !== 8'd255) begin
          errors++; $display("FAIL wrap_255: got %0d expected 255", press_count);
        end
      end
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++; $display("FAIL wrap_0: got %0d expected 0", press_count);
    end
  endtask

  task automatic test_reset_mid_press;
    int t, r0, p0;
    apply_reset();
    r0 = n_rel;
    btn_in = 1'b0; tick(20);
    checks++;
    if (btn_level !== 1'b1 || press_count !== 8'd1) begin
      errors++; $display("FAIL midrst_pre: level %b count %0d expected 1 1", btn_level, press_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0000 || press_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_async: flags %b count %0d expected 0000 0",
               {btn_level, press_pulse, release_pulse, long_press_pulse}, press_count);
    end
    tick(3);
    p0 = n_press;
    rst_n = 1'b1;
    t = cyc;
    tick(15);
    checks++;
    if (n_press - p0 != 1 || last_press != t + 10) begin
      errors++;
      $display("FAIL held_reset_press: got %0d pulses at %0d expected 1 at %0d", n_press - p0, last_press, t + 10);
    end
    checks++;
    if (n_rel - r0 != 0) begin
      errors++; $display("FAIL midrst_norelease: got %0d releases expected 0", n_rel - r0);
    end
    btn_in = 1'b1; tick(15);
  endtask

  task automatic test_pulse_shape;
    checks++;
    if (n_overlap != 0 || n_wide != 0) begin
      errors++;
      $display("FAIL pulse_shape: overlaps %0d wide %0d expected 0 0", n_overlap, n_wide);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_bouncy_press();
    test_release_bounce();
    test_short_press();
    test_wrap();
    test_reset_mid_press();
    test_pulse_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front-panel or GPIO input conditioner for board bring-up designs. It is the input-side counterpart of the LED blink counter: a raw asynchronous mechanical input is turned into clean, single-cycle events in the sysclk2 domain.
- Stages: 2-flop synchronizer, then a debounce state machine, then press/release/long-press event generation and a press counter.
- Its outputs feed LED logic or control registers directly.

Parameters:
- ACTIVE_LOW, 1, 1 = btn_in asserted when low; 0 = asserted when high
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range is >= 2
- LONG_PRESS_CYCLES, 200000000, cycles held after an accepted press before long_press_pulse fires (2 s at 100 MHz); must be > DEBOUNCE_CYCLES
- COUNT_WIDTH, 8, width of press_count

Ports:
- sysclk2, input, 1, single clock (100 MHz board clock after IBUFDS)
- rst_n, input, 1, asynchronous active-low reset
- btn_in, input, 1, raw asynchronous button/switch pin
- btn_level, output, 1, debounced level; 1 = pressed
- press_pulse, output, 1, one-cycle pulse on an accepted press
- release_pulse, output, 1, one-cycle pulse on an accepted release
- long_press_pulse, output, 1, one-cycle pulse when a press has been held LONG_PRESS_CYCLES
- press_count, output, COUNT_WIDTH, count of accepted presses

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - Both synchronizer flops load the inactive level.
  - FSM goes to IDLE and all counters clear.
  - btn_level, press_pulse, release_pulse, long_press_pulse and press_count are all 0.
- Polarity: act = sync2 XOR ACTIVE_LOW, where sync2 is the second synchronizer flop. Everything downstream uses act only.
- Counter widths: db_cnt is $clog2(DEBOUNCE_CYCLES+1); lp_cnt is $clog2(LONG_PRESS_CYCLES+1).
- FSM states:
  - IDLE:
    - act=1 -> DB_PRESS with db_cnt=1.
  - DB_PRESS:
    - act=0 -> IDLE with db_cnt=0 (bounce rejected, no event).
    - act=1 and db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Registered press_pulse=1 for 1 cycle; btn_level=1; press_count+1; lp_cnt=0.
    - Otherwise db_cnt+1.
  - PRESSED:
    - lp_cnt increments each cycle, saturating at LONG_PRESS_CYCLES.
    - long_press_pulse=1 in exactly the one cycle where lp_cnt transitions to LONG_PRESS_CYCLES. It never repeats within one press.
    - act=0 -> DB_RELEASE with db_cnt=1.
  - DB_RELEASE:
    - act=1 -> PRESSED (release rejected). lp_cnt is not cleared and keeps counting, so the long-press timing spans the bounce.
    - act=0 and db_cnt==DEBOUNCE_CYCLES-1 -> IDLE. release_pulse=1 for 1 cycle; btn_level=0.
    - Otherwise db_cnt+1.
    - lp_cnt continues counting in this state as well.
- Latency, with btn_in stable after an edge sampled at clock edge k:
  - press_pulse/btn_level change is visible after edge k+1+DEBOUNCE_CYCLES.
  - Release latency is identical.
- Pulse exclusivity: press_pulse, release_pulse and long_press_pulse are mutually exclusive in any cycle, and each is high for exactly one cycle.
- press_count wraps modulo 2^COUNT_WIDTH, with no saturation and no flag.
- Held at reset release: an input that is active when rst_n deasserts produces a press_pulse after the normal debounce latency. This is intentional.
- Reset mid-press: outputs return to 0 immediately and asynchronously. No release_pulse is emitted.
- A bounce lasting 1 cycle or DEBOUNCE_CYCLES-1 cycles never produces an event.

Test Plan (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=40, ACTIVE_LOW=1):
- Clean press: btn_in 1->0, held 100 cycles then 1 ->
  - press_pulse exactly 1 cycle, 9 cycles after the sample edge;
  - long_press_pulse once, 40 cycles after press_pulse;
  - release_pulse 9 cycles after btn_in returns to 1;
  - press_count=1.
- Bounce rejection: btn_in low for 7 cycles, high for 3, repeated 5 times, then high -> no pulses, btn_level=0, press_count=0.
- Bouncy press: alternate 0/1 for 20 cycles ending low and held 20 cycles -> exactly one press_pulse, 9 cycles after the final stable low sample.
- Release bounce: while pressed, btn_in high for 5 cycles then low again ->
  - no release_pulse, btn_level stays 1;
  - long_press_pulse still fires 40 cycles after the original press_pulse.
- Short press: hold 20 cycles (<40) -> press_pulse and release_pulse only, with no long_press_pulse.
- Wrap and reset:
  - 256 clean presses -> press_count=0 after the last.
  - rst_n low mid-press -> all outputs 0 within the same cycle.
  - btn_in held low through reset release -> press_pulse 9 cycles after the first sampled edge.
